// File: rtl/systolic_writeback.sv
// Drains one N x N accumulator tile from a systolic array diagonal-by-diagonal,
// quantizes it and writes it to SRAM row by row. Define WB_RELU_EN to clamp negatives to 0.
module systolic_writeback #(
    parameter int ARRAY_SIZE    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int OUTCOME_WIDTH = 2*DATA_WIDTH+5,
    parameter int ADDR_WIDTH    = 10
) (
    input  logic                             clk,
    input  logic                             srstn,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [3:0]                       shift,
    input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
    output logic [5:0]                       matrix_index,
    output logic                             sram_wen,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_wdata,
    input  logic                             sram_ready,
    output logic                             busy,
    output logic                             done
);
    localparam int SW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam logic signed [OUTCOME_WIDTH-1:0] Q_MAX =
        {{(OUTCOME_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [OUTCOME_WIDTH-1:0] Q_MIN = ~Q_MAX;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_WRITE, S_DONE} state_t;

    state_t                  r_state;
    logic [SW-1:0]           r_step;
    logic [SW-1:0]           r_row;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [3:0]              r_shift;
    logic [DATA_WIDTH-1:0]   r_buf [ARRAY_SIZE][ARRAY_SIZE];

    logic [DATA_WIDTH-1:0]   w_q   [ARRAY_SIZE];
    logic [SW-1:0]           w_col [ARRAY_SIZE];

    function automatic logic [DATA_WIDTH-1:0] quantize(
        input logic signed [OUTCOME_WIDTH-1:0] v,
        input logic [3:0]                      sh
    );
        logic signed [OUTCOME_WIDTH-1:0] x;
        logic signed [OUTCOME_WIDTH-1:0] s;
        x = v;
`ifdef WB_RELU_EN
        if (x[OUTCOME_WIDTH-1]) x = '0;
`endif
        s = x >>> sh;
        if (s > Q_MAX)      return Q_MAX[DATA_WIDTH-1:0];
        else if (s < Q_MIN) return Q_MIN[DATA_WIDTH-1:0];
        else                return s[DATA_WIDTH-1:0];
    endfunction

    // Lane i at step k holds element C[i][(k-i) mod N].
    always_comb begin
        for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
            w_q[i]   = quantize(mul_outcome[i*OUTCOME_WIDTH +: OUTCOME_WIDTH], r_shift);
            w_col[i] = SW'((32'(r_step) + 32'(ARRAY_SIZE) - i) % 32'(ARRAY_SIZE));
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_row   <= '0;
            r_base  <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_shift <= shift;
                        r_step  <= '0;
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_step <= r_step + SW'(1);
                    if (r_step == SW'(ARRAY_SIZE-1)) begin
                        r_row   <= '0;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (sram_ready) begin
                        if (r_row == SW'(ARRAY_SIZE-1)) r_state <= S_DONE;
                        else                            r_row   <= r_row + SW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srstn && r_state == S_CAPTURE) begin
            for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
                r_buf[i][w_col[i]] <= w_q[i];
            end
        end
    end

    // Outputs decode straight from registered state, so they are zero in reset.
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign sram_wen     = (r_state == S_WRITE);
    assign matrix_index = (r_state == S_CAPTURE) ? 6'(r_step) : '0;
    assign sram_addr    = (r_state == S_WRITE) ? r_base + ADDR_WIDTH'(r_row) : '0;

    always_comb begin
        sram_wdata = '0;
        if (r_state == S_WRITE) begin
            for (int unsigned j = 0; j < ARRAY_SIZE; j++) begin
                sram_wdata[(ARRAY_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH] = r_buf[r_row][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_writeback.sv
// Scoreboard bench for systolic_writeback: the stimulus pushes expected SRAM rows,
// a negedge monitor compares every presented write against the queue head.
module tb_systolic_writeback;
    localparam int N  = 8;
    localparam int DW = 8;
    localparam int OW = 2*DW+5;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            srstn = 1'b0;
    logic            start = 1'b0;
    logic            sram_ready = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [3:0]      shift = '0;
    logic [N*OW-1:0] mul_outcome;
    logic [5:0]      matrix_index;
    logic            sram_wen;
    logic [AW-1:0]   sram_addr;
    logic [N*DW-1:0] sram_wdata;
    logic            busy;
    logic            done;

    int n_tests = 0;
    int n_fail  = 0;
    int C [N][N];

    typedef struct {
        logic [AW-1:0]   addr;
        logic [N*DW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    systolic_writeback #(
        .ARRAY_SIZE(N),
        .DATA_WIDTH(DW),
        .OUTCOME_WIDTH(OW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .srstn(srstn), .start(start), .base_addr(base_addr), .shift(shift),
        .mul_outcome(mul_outcome), .matrix_index(matrix_index), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_ready(sram_ready),
        .busy(busy), .done(done)
    );

    // Array model: diagonal k puts C[i][(k-i) mod N] on lane i.
    always_comb begin
        mul_outcome = '0;
        for (int i = 0; i < N; i++)
            mul_outcome[i*OW +: OW] = OW'(C[i][(int'(matrix_index) + N - i) % N]);
    end

    function automatic logic [DW-1:0] qmodel(input int v, input int sh);
        int d;
        int q;
`ifdef WB_RELU_EN
        if (v < 0) v = 0;
`endif
        d = 1 << sh;
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return 8'(q);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_tile(input logic [AW-1:0] b, input int sh);
        wr_t w;
        for (int r = 0; r < N; r++) begin
            w.addr = AW'(int'(b) + r);
            w.data = '0;
            for (int j = 0; j < N; j++)
                w.data = (w.data << DW) | (N*DW)'(qmodel(C[r][j], sh));
            exp_q.push_back(w);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                C[i][j] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 600)) - 300
                                                      : int'($urandom_range(0, (1 << OW) - 1)) - (1 << (OW-1));
    endtask

    always @(negedge clk) begin
        if (sram_wen) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", sram_addr, sram_wdata);
            end else begin
                chk("wr_addr", 64'(sram_addr), 64'(exp_q[0].addr));
                chk("wr_data", 64'(sram_wdata), 64'(exp_q[0].data));
                if (sram_ready) void'(exp_q.pop_front());
            end
        end
    end

    // mode: 0 ready high, 1 stall row 2, 2 random ready, 3 start in capture, 4 reset at row 4
    task automatic run_tile(input logic [AW-1:0] b, input logic [3:0] sh, input int mode, input int exp_done);
        int cyc;
        push_tile(b, int'(sh));
        base_addr  = b;
        shift      = sh;
        start      = 1'b1;
        sram_ready = 1'b1;
        @(posedge clk); #2;
        start     = 1'b0;
        base_addr = AW'($urandom);
        shift     = 4'($urandom);
        cyc = 1;
        forever begin
            case (mode)
                1: sram_ready = !(cyc >= 11 && cyc <= 13);
                2: sram_ready = ($urandom_range(0, 9) < 6);
                3: start = (cyc == 3);
                4: if (cyc == 13) srstn = 1'b0;
                default: sram_ready = 1'b1;
            endcase
            @(negedge clk);
            if (cyc <= N) begin
                chk("cap_index", 64'(matrix_index), 64'(cyc - 1));
                chk("cap_wen", 64'(sram_wen), 64'd0);
                chk("cap_busy", 64'(busy), 64'd1);
            end
            if (mode == 4 && cyc == 14) begin
                chk("abort_wen", 64'(sram_wen), 64'd0);
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_done", 64'(done), 64'd0);
                break;
            end
            if (done) begin
                if (exp_done > 0) chk("done_cycle", 64'(cyc), 64'(exp_done));
                break;
            end
            if (cyc >= 400) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_timeout: got no done by cycle %0d, expected done", cyc);
                break;
            end
            @(posedge clk); #2;
            cyc++;
        end
        start = 1'b0;
        if (mode != 4) begin
            @(posedge clk); #2;
            @(negedge clk);
            chk("done_pulse_end", 64'(done), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("queue_drained", 64'(exp_q.size()), 64'd0);
        end
        @(posedge clk); #2;
    endtask

    initial begin
        srstn      = 1'b0;
        sram_ready = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                C[i][j] = i*8 + j;
        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_index", 64'(matrix_index), 64'd0);
        chk("rst_wen", 64'(sram_wen), 64'd0);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_wdata", 64'(sram_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk); #2;
        srstn = 1'b1;
        @(posedge clk); #2;

        run_tile(10'h100, 4'd0, 0, 17);

        fill_random();
        C[0][0] = 1000;
        C[3][5] = -1000;
        run_tile(10'h040, 4'd2, 0, 17);

        fill_random();
        C[2][2] = -5;
        run_tile(10'h200, 4'd1, 0, 17);

        fill_random();
        C[7][7] = -50;
        run_tile(10'h080, 4'd0, 0, 17);

        fill_random();
        run_tile(10'h123, 4'd3, 1, 20);

        fill_random();
        run_tile(10'h2A0, 4'd4, 3, 17);

        fill_random();
        run_tile(10'h3FC, 4'd0, 4, 0);
        srstn = 1'b1;
        exp_q.delete();
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("post_abort_done", 64'(done), 64'd0);
            chk("post_abort_wen", 64'(sram_wen), 64'd0);
            @(posedge clk); #2;
        end

        fill_random();
        run_tile(10'h3FC, 4'd1, 0, 17);

        for (int t = 0; t < 6; t++) begin
            fill_random();
            run_tile(AW'($urandom), 4'($urandom), 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
